encoder_32_to_5_scan: RTL and testbench

Sequential counterpart to the 5-to-32 register-select decoder. It takes a 32-bit request vector, such as a pending-writeback or dirty-register mask, and emits the 5-bit index of each set bit, one per handshake. Each served bit is cleared as it is handed out. It sits between hazard/scoreboard logic and register-file address muxing and turns one-hot or multi-hot masks back into register addresses.

---
 rtl/encoder_pkg.sv | 25 ++
 rtl/encoder_32_to_5_scan_if.sv | 40 ++++
 rtl/priority_encoder_32.sv | 16 +
 rtl/encoder_32_to_5_scan.sv | 130 +++++++++++++
 tb/tb_encoder_32_to_5_scan.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// rtl/encoder_pkg.sv - shared widths, FSM encoding and lowest-set-bit helper
package encoder_pkg;

  localparam int WIDTH = 32;
  localparam int ADR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [ADR_W-1:0] lowest_set(input logic [WIDTH-1:0] vec);
    logic [ADR_W-1:0] idx;
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ADR_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/encoder_32_to_5_scan_if.sv
// rtl/encoder_32_to_5_scan_if.sv - load/index handshake bundle for the scan encoder
interface encoder_32_to_5_scan_if #(
  parameter int WIDTH = 32,
  parameter int ADR_W = 5
);

  logic             load;
  logic [WIDTH-1:0] req_vec;
  logic             busy;
  logic [ADR_W-1:0] adr;
  logic             adr_valid;
  logic             adr_ready;
  logic             done;
  logic [ADR_W:0]   count;

  // Requester side: starts jobs and consumes indices.
  modport master (
    output load,
    output req_vec,
    output adr_ready,
    input  busy,
    input  adr,
    input  adr_valid,
    input  done,
    input  count
  );

  // Encoder side.
  modport slave (
    input  load,
    input  req_vec,
    input  adr_ready,
    output busy,
    output adr,
    output adr_valid,
    output done,
    output count
  );

endinterface

// File: rtl/priority_encoder_32.sv
// rtl/priority_encoder_32.sv - combinational lowest-set-bit encoder for a 32-bit mask
module priority_encoder_32
  import encoder_pkg::*;
(
  input  logic [WIDTH-1:0] vec,
  output logic [ADR_W-1:0] idx,
  output logic             found
);

  // Pure combinational search; idx is 0 when nothing is set.
  always_comb begin
    idx   = lowest_set(vec);
    found = |vec;
  end

endmodule

// File: rtl/encoder_32_to_5_scan.sv
// rtl/encoder_32_to_5_scan.sv - serialises a request mask into register indices; ENCODER_ROUND_ROBIN_EN selects rotating priority
module encoder_32_to_5_scan
  import encoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  encoder_32_to_5_scan_if.slave bus
);

  localparam int CW = ADR_W + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             accept;

  logic [WIDTH-1:0] sel_vec;
  logic [ADR_W-1:0] enc_idx;
  logic             enc_found;
  logic [ADR_W-1:0] sel_idx;

  // A beat is taken only while an index is being offered.
  assign accept = (state_q == SCAN) && bus.adr_ready;

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [ADR_W-1:0]   ptr_q, ptr_d;
  logic [ADR_W-1:0]   start;
  logic [2*WIDTH-1:0] dbl;

  // The last served index becomes the new priority origin.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = adr_q;
    end
  end

  // Rotate the mask so that bit ptr+1 lands at position 0, encode, then undo the rotation.
  always_comb begin
    start   = ptr_d + ADR_W'(1);
    dbl     = {pending_d, pending_d} >> start;
    sel_vec = dbl[WIDTH-1:0];
    sel_idx = enc_idx + start;
  end

  // Pointer persists across jobs; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    sel_vec = pending_d;
    sel_idx = enc_idx;
  end
`endif

  priority_encoder_32 u_penc (
    .vec   (sel_vec),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Next-state, pending mask and count; Load is only looked at in IDLE.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          pending_d = bus.req_vec;
          count_d   = '0;
          state_d   = (|bus.req_vec) ? SCAN : FIN;
        end
      end
      SCAN: begin
        if (accept) begin
          pending_d = pending_q & ~(WIDTH'(1) << adr_q);
          count_d   = count_q + CW'(1);
          if (pending_d == '0) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The offered index only moves on job start or an accepted beat, so it is stable under stall.
  always_comb begin
    adr_d = adr_q;
    if ((state_d == SCAN) && enc_found && ((state_q != SCAN) || accept)) begin
      adr_d = sel_idx;
    end
  end

  // State registers; reset abandons any job without a Done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      adr_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      adr_q     <= adr_d;
      count_q   <= count_d;
    end
  end

  // Status outputs are plain state decodes, so Done and AdrValid can never overlap.
  assign bus.busy      = (state_q == SCAN);
  assign bus.adr_valid = (state_q == SCAN);
  assign bus.done      = (state_q == FIN);
  assign bus.adr       = adr_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_encoder_32_to_5_scan.sv
// tb/tb_encoder_32_to_5_scan.sv - scoreboard bench for encoder_32_to_5_scan
module tb_encoder_32_to_5_scan;

  logic clk;
  logic rst_n;

  encoder_32_to_5_scan_if #(.WIDTH(32), .ADR_W(5)) bus ();

  encoder_32_to_5_scan dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  int mptr     = 0;
  int beats    = 0;
  int first_adr = -1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue the indices a job should produce, in service order.
  task automatic model_push(input logic [31:0] mask, output int n);
    logic [31:0] p;
    int start;
    int idx;
    bit hit;
    p = mask;
    n = 0;
    while (p != 0) begin
`ifdef ENCODER_ROUND_ROBIN_EN
      start = (mptr + 1) % 32;
`else
      start = 0;
`endif
      idx = 0;
      hit = 0;
      for (int k = 0; k < 32; k++) begin
        if (!hit && p[(start + k) % 32]) begin
          idx = (start + k) % 32;
          hit = 1;
        end
      end
      exp_q.push_back(idx);
      p[idx] = 1'b0;
      mptr = idx;
      n++;
    end
  endtask

  // Monitor: every offered index must match the head of the scoreboard; pop on accept.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.adr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("extra_beat", 64'd1, 64'd0);
      end else begin
        check_val(bus.adr_ready ? "adr_beat" : "adr_hold", 64'(bus.adr), 64'(exp_q[0]));
        if (bus.adr_ready === 1'b1) begin
          if (beats == 0) first_adr = int'(bus.adr);
          beats++;
          void'(exp_q.pop_front());
        end
      end
      check_val("valid_done_excl", 64'(bus.done), 64'd0);
    end
  end

  task automatic run_job(input logic [31:0] mask, input int stall, input bit mid_load);
    int n;
    int cyc;
    bit seen;
    model_push(mask, n);
    beats = 0;
    first_adr = -1;
    @(posedge clk); #1;
    bus.load = 1'b1; bus.req_vec = mask; bus.adr_ready = 1'b0;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.req_vec = $urandom;
    cyc = 0;
    seen = 0;
    bus.adr_ready = (stall == 0);
    @(negedge clk);
    check_val("busy_first", 64'(bus.busy), 64'(mask != 0));
    check_val("valid_first", 64'(bus.adr_valid), 64'(mask != 0));
    while (!seen && cyc < 100) begin
      if (bus.done === 1'b1) begin
        seen = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        bus.adr_ready = (cyc >= stall);
        bus.load = mid_load && (cyc == 10);
        if (bus.load) bus.req_vec = 32'h0000_0003;
        @(negedge clk);
      end
    end
    check_val("done_seen", 64'(seen), 64'd1);
    check_val("count_at_done", 64'(bus.count), 64'(n));
    check_val("busy_at_done", 64'(bus.busy), 64'd0);
    check_val("beats", 64'(beats), 64'(n));
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    bus.adr_ready = 1'b0;
    bus.load = 1'b0;
    @(negedge clk);
    check_val("done_pulse", 64'(bus.done), 64'd0);
    check_val("count_hold", 64'(bus.count), 64'(n));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.load = 1'b0;
    bus.req_vec = '0;
    bus.adr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_busy", 64'(bus.busy), 64'd0);
    check_val("rst_valid", 64'(bus.adr_valid), 64'd0);
    check_val("rst_adr", 64'(bus.adr), 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_count", 64'(bus.count), 64'd0);

    run_job(32'h0000_0000, 0, 1'b0);
    run_job(32'h8000_0001, 0, 1'b0);
    run_job(32'h0000_0014, 3, 1'b0);
    run_job(32'hFFFF_FFFF, 0, 1'b1);

    // Load held through the FIN cycle of an empty job: second edge must be ignored.
    @(posedge clk); #1;
    bus.load = 1'b1; bus.req_vec = 32'h0;
    @(posedge clk); #1;
    bus.req_vec = 32'h0000_0008;
    @(negedge clk);
    check_val("fin_done", 64'(bus.done), 64'd1);
    @(posedge clk); #1;
    bus.load = 1'b0;
    @(negedge clk);
    check_val("fin_load_busy", 64'(bus.busy), 64'd0);
    check_val("fin_load_valid", 64'(bus.adr_valid), 64'd0);
    check_val("fin_load_done", 64'(bus.done), 64'd0);

    // Mid-job reset: one beat taken, then reset abandons the job silently.
    model_push(32'h0000_00F0, n);
    beats = 0;
    @(posedge clk); #1;
    bus.load = 1'b1; bus.req_vec = 32'h0000_00F0;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.adr_ready = 1'b1;
    @(posedge clk); #1;
    bus.adr_ready = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    mptr = 0;
    @(negedge clk);
    check_val("mid_rst_beats", 64'(beats), 64'd1);
    check_val("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_val("mid_rst_valid", 64'(bus.adr_valid), 64'd0);
    check_val("mid_rst_count", 64'(bus.count), 64'd0);
    check_val("mid_rst_done", 64'(bus.done), 64'd0);

    run_job(32'h0000_0001, 0, 1'b0);
    check_val("after_rst_adr", 64'(first_adr), 64'd0);
    run_job(32'h0000_0020, 0, 1'b0);
    check_val("single_5", 64'(first_adr), 64'd5);
    run_job(32'h0000_0041, 0, 1'b0);
`ifdef ENCODER_ROUND_ROBIN_EN
    check_val("rr_first", 64'(first_adr), 64'd6);
`else
    check_val("fixed_first", 64'(first_adr), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
